// File: rtl/dm_pkg.sv
// Shared widths, control-field layout and I/O address defaults for the
// data-memory stage.
package dm_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned RD_W   = 2;
  localparam int unsigned CTRL_W = 4;

  localparam int unsigned CTRL_WB = 3;
  localparam int unsigned CTRL_MW = 2;
  localparam int unsigned CTRL_MR = 1;
  localparam int unsigned CTRL_V  = 0;

  localparam logic [ADDR_W-1:0] DEF_IO_IN_ADDR  = 8'hFE;
  localparam logic [ADDR_W-1:0] DEF_IO_OUT_ADDR = 8'hFF;

  typedef logic [CTRL_W-1:0] ctrl_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [RD_W-1:0]   rd;
    logic              en;
  } wb_t;

endpackage

// File: rtl/dm_ram.sv
// Byte-wide data RAM: synchronous write, asynchronous read.
module dm_ram
  import dm_pkg::*;
#(
  parameter int unsigned DEPTH = 256
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/dm_stage.sv
// Data-memory pipeline stage: load/store decode, memory-mapped I/O bytes,
// write-back result select, DM/WB register and execute-stage forwarding.
module dm_stage
  import dm_pkg::*;
#(
  parameter int unsigned       DEPTH       = 256,
  parameter logic [ADDR_W-1:0] IO_IN_ADDR  = DEF_IO_IN_ADDR,
  parameter logic [ADDR_W-1:0] IO_OUT_ADDR = DEF_IO_OUT_ADDR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] store_data,
  input  logic [DATA_W-1:0] alu_result,
  input  ctrl_t             ctrl,
  input  logic [RD_W-1:0]   rd,
  input  logic [DATA_W-1:0] io_in,
  output logic [DATA_W-1:0] wb_data,
  output logic [RD_W-1:0]   wb_reg,
  output logic              wb_en,
  output logic [DATA_W-1:0] fwd_data,
  output logic [RD_W-1:0]   fwd_reg,
  output logic              fwd_en,
  output logic [DATA_W-1:0] io_out,
  output logic              ctrl_err
);

  logic              valid_c;
  logic              we_c;
  logic              re_c;
  logic              illegal_c;
  logic              ram_we_c;
  logic [DATA_W-1:0] ram_rdata;
  logic [DATA_W-1:0] result_c;

  wb_t               wb_q, wb_d;
  logic [DATA_W-1:0] io_out_q, io_out_d;
  logic              ctrl_err_q, ctrl_err_d;

  assign valid_c   = ctrl[CTRL_V];
  assign we_c      = valid_c & ctrl[CTRL_MW];
  assign re_c      = valid_c & ctrl[CTRL_MR] & ~ctrl[CTRL_MW];
  assign illegal_c = valid_c & ctrl[CTRL_MW] & ctrl[CTRL_MR];

  // The output port address shadows its RAM byte; reset blocks all writes.
  assign ram_we_c = we_c & ~rst & (address != IO_OUT_ADDR);

  dm_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we_c),
    .addr  (address),
    .wdata (store_data),
    .rdata (ram_rdata)
  );

  always_comb begin
    result_c = alu_result;
    if (re_c) begin
      if (address == IO_IN_ADDR) begin
        result_c = io_in;
      end else if (address == IO_OUT_ADDR) begin
        result_c = io_out_q;
      end else begin
        result_c = ram_rdata;
      end
    end
  end

  assign fwd_data = result_c;
  assign fwd_reg  = rd;
  assign fwd_en   = valid_c & ctrl[CTRL_WB] & ~(ctrl[CTRL_MW] & ctrl[CTRL_MR]);

  always_comb begin
    wb_d       = '{data: result_c, rd: rd, en: fwd_en};
    io_out_d   = io_out_q;
    ctrl_err_d = ctrl_err_q | illegal_c;
    if (we_c && (address == IO_OUT_ADDR)) begin
      io_out_d = store_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_q       <= '0;
      io_out_q   <= '0;
      ctrl_err_q <= 1'b0;
    end else begin
      wb_q       <= wb_d;
      io_out_q   <= io_out_d;
      ctrl_err_q <= ctrl_err_d;
    end
  end

  assign wb_data  = wb_q.data;
  assign wb_reg   = wb_q.rd;
  assign wb_en    = wb_q.en;
  assign io_out   = io_out_q;
  assign ctrl_err = ctrl_err_q;

endmodule

// File: tb/tb_dm_stage.sv
// Scoreboard bench for dm_stage: inputs change on the falling edge like the
// EXE/DM register; a monitor checks the DM/WB outputs after each rising edge.
module tb_dm_stage;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] address, store_data, alu_result, io_in;
  logic [3:0] ctrl;
  logic [1:0] rd;
  logic [7:0] wb_data, fwd_data, io_out;
  logic [1:0] wb_reg, fwd_reg;
  logic       wb_en, fwd_en, ctrl_err;

  typedef struct packed {
    logic       care;
    logic [7:0] data;
    logic [1:0] rd;
    logic       en;
    logic [7:0] io_out;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [7:0] m_mem [256];
  logic [7:0] m_io_out = 8'h00;
  logic       m_err    = 1'b0;

  always #5 clk = ~clk;

  dm_stage dut (
    .clk        (clk),
    .rst        (rst),
    .address    (address),
    .store_data (store_data),
    .alu_result (alu_result),
    .ctrl       (ctrl),
    .rd         (rd),
    .io_in      (io_in),
    .wb_data    (wb_data),
    .wb_reg     (wb_reg),
    .wb_en      (wb_en),
    .fwd_data   (fwd_data),
    .fwd_reg    (fwd_reg),
    .fwd_en     (fwd_en),
    .io_out     (io_out),
    .ctrl_err   (ctrl_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One instruction per cycle; the model computes the architectural outcome.
  task automatic issue(input logic r, input logic [3:0] c, input logic [7:0] a,
                       input logic [7:0] sd, input logic [7:0] alu,
                       input logic [1:0] d, input logic [7:0] ii);
    exp_t       e;
    logic [7:0] res;
    logic       v, mr, mw, f_en;
    @(negedge clk);
    rst = r; ctrl = c; address = a; store_data = sd;
    alu_result = alu; rd = d; io_in = ii;
    v  = c[0];
    mr = c[1];
    mw = c[2];
    if (v && mr && !mw) begin
      if (a == 8'hFE)      res = ii;
      else if (a == 8'hFF) res = m_io_out;
      else                 res = m_mem[a];
    end else begin
      res = alu;
    end
    f_en = v & c[3] & ~(mw & mr);
    if (r) begin
      m_io_out = 8'h00;
      m_err    = 1'b0;
      e = '{care: 1'b1, data: 8'h00, rd: 2'd0, en: 1'b0, io_out: 8'h00, err: 1'b0};
    end else begin
      if (v && mw) begin
        if (a == 8'hFF) m_io_out = sd;
        else            m_mem[a] = sd;
      end
      if (v && mw && mr) m_err = 1'b1;
      e = '{care: v, data: res, rd: d, en: f_en, io_out: m_io_out, err: m_err};
    end
    exp_q.push_back(e);
    #1;
    chk("fwd_data", 32'(fwd_data), 32'(res));
    chk("fwd_reg",  32'(fwd_reg),  32'(d));
    chk("fwd_en",   32'(fwd_en),   32'(f_en));
  endtask

  // Monitor: one expected DM/WB state per rising edge that followed an issue.
  initial begin
    exp_t me;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        me = exp_q.pop_front();
        if (me.care) begin
          chk("wb_data", 32'(wb_data), 32'(me.data));
          chk("wb_reg",  32'(wb_reg),  32'(me.rd));
        end
        chk("wb_en",    32'(wb_en),    32'(me.en));
        chk("io_out",   32'(io_out),   32'(me.io_out));
        chk("ctrl_err", 32'(ctrl_err), 32'(me.err));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] a;
    rst = 1'b1; ctrl = 4'h0; address = 8'h00; store_data = 8'h00;
    alu_result = 8'h00; rd = 2'd0; io_in = 8'h00;

    // Reset held two cycles.
    issue(1'b1, 4'b0000, 8'h00, 8'h00, 8'h00, 2'd0, 8'h00);
    issue(1'b1, 4'b0000, 8'h00, 8'h00, 8'h00, 2'd0, 8'h00);

    // Give every reachable RAM byte a known value.
    for (int i = 0; i < 255; i++) begin
      issue(1'b0, 4'b0101, 8'(i), 8'($urandom_range(0, 255)), 8'h00, 2'd0, 8'h00);
    end

    // Store then load the same address back-to-back.
    issue(1'b0, 4'b0101, 8'h10, 8'h5A, 8'h00, 2'd0, 8'h00);
    issue(1'b0, 4'b1011, 8'h10, 8'h00, 8'h99, 2'd2, 8'h00);

    // I/O bytes.
    issue(1'b0, 4'b0101, 8'hFF, 8'hC3, 8'h00, 2'd0, 8'h00);
    issue(1'b0, 4'b1011, 8'hFF, 8'h00, 8'h00, 2'd3, 8'h00);
    issue(1'b0, 4'b1011, 8'hFE, 8'h00, 8'h00, 2'd1, 8'h3C);

    // ALU pass-through and bubble.
    issue(1'b0, 4'b1001, 8'h10, 8'h00, 8'h7F, 2'd1, 8'h00);
    issue(1'b0, 4'b1110, 8'h10, 8'hEE, 8'h12, 2'd3, 8'h00);
    issue(1'b0, 4'b1011, 8'h10, 8'h00, 8'h00, 2'd0, 8'h00);

    // Illegal control: store executes, write-back dropped, error sticks.
    issue(1'b0, 4'b1111, 8'h20, 8'h11, 8'h55, 2'd2, 8'h00);
    issue(1'b0, 4'b1011, 8'h20, 8'h00, 8'h00, 2'd3, 8'h00);
    issue(1'b0, 4'b1001, 8'h20, 8'h00, 8'h44, 2'd1, 8'h00);

    // Reset during a store discards it.
    issue(1'b1, 4'b0101, 8'h30, 8'hAA, 8'h00, 2'd0, 8'h00);
    issue(1'b0, 4'b1011, 8'h30, 8'h00, 8'h00, 2'd2, 8'h00);

    // Randomized instruction stream.
    for (int i = 0; i < 2000; i++) begin
      case ($urandom_range(0, 9))
        0:       a = 8'hFE;
        1:       a = 8'hFF;
        2:       a = 8'($urandom_range(0, 255));
        default: a = 8'h40 + 8'($urandom_range(0, 7));
      endcase
      issue(($urandom_range(0, 49) == 0), 4'($urandom_range(0, 15)), a,
            8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
            2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
    end

    @(negedge clk);
    ctrl = 4'h0;
    repeat (3) @(negedge clk);
    chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
